// File: rtl/histo_pkg.sv
// rtl/histo_pkg.sv - shared defaults and read-path FSM encoding for the histogram engine
package histo_pkg;

    localparam int GRAY_W_DEF  = 8;
    localparam int HISTO_W_DEF = 20;
    localparam int DP_LAT_DEF  = 3;

    // RUN: issue allowed; HOLD: engine busy; DRAIN: busy fell, older reads still in flight
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } hraState_t;

endpackage

// File: rtl/hra_rr_arbiter.sv
// rtl/hra_rr_arbiter.sv - round-robin one-hot grant with registered rotating pointer
//  iClk, iRst_n : clock, asynchronous active-low reset
//  iReq         : request vector
//  iEn          : grant allowed this cycle
//  oGnt         : one-hot grant (combinational)
//  oGntIdx      : index of the granted requester (valid when oIssue)
//  oIssue       : a grant is given this cycle
module hra_rr_arbiter #(
    parameter int NREQ = 3,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [NREQ-1:0]  iReq,
    input  logic             iEn,
    output logic [NREQ-1:0]  oGnt,
    output logic [PTR_W-1:0] oGntIdx,
    output logic             oIssue
);

    localparam logic [PTR_W:0]   NREQ_W = (PTR_W+1)'(NREQ);
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0]  ptr;
    logic [2*NREQ-1:0] reqDbl;
    logic [NREQ-1:0]   reqRot;
    logic [PTR_W-1:0]  first;
    logic [PTR_W:0]    sum;
    logic [PTR_W-1:0]  gntIdx;
    logic              issue;

    // Rotate the request vector so the pointer position sits at bit 0, take the
    // lowest set bit, then rotate the offset back into an absolute index.
    always_comb begin
        reqDbl = {iReq, iReq};
        reqRot = reqDbl[ptr +: NREQ];
        first  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (reqRot[i]) first = PTR_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, first};
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        gntIdx = sum[PTR_W-1:0];
        issue  = iEn && (|iReq);
        oGnt   = issue ? (NREQ'(1) << gntIdx) : '0;
    end

    assign oGntIdx = gntIdx;
    assign oIssue  = issue;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (gntIdx == LAST) ? '0 : gntIdx + 1'b1;
        end
    end

endmodule

// File: rtl/histo_read_arbiter.sv
// rtl/histo_read_arbiter.sv - shares the histogram engine read port among NREQ requesters
//  iClk, iRst_n   : clock, asynchronous active-low reset
//  iReq, iAddr    : per-requester read request and gray address (slice i = requester i)
//  iHistBusy      : engine recomputing, no new reads
//  oGnt           : one-hot accept pulse
//  oReadGray      : registered address to the engine read port
//  iGrayHisto     : engine bin count, DP_LAT cycles after oReadGray
//  iGrayCumHisto  : engine cumulative count, same timing
//  oRdValid       : one-hot return strobe
//  oRdGray/Histo/Cum : returned address and data, broadcast, held between strobes
//  oIdle          : nothing requested, nothing in flight, state RUN
module histo_read_arbiter
    import histo_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int DP_LAT  = DP_LAT_DEF,
    parameter int GRAY_W  = GRAY_W_DEF,
    parameter int HISTO_W = HISTO_W_DEF
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic [NREQ-1:0]          iReq,
    input  logic [NREQ*GRAY_W-1:0]   iAddr,
    input  logic                     iHistBusy,
    output logic [NREQ-1:0]          oGnt,
    output logic [GRAY_W-1:0]        oReadGray,
    input  logic [HISTO_W-1:0]       iGrayHisto,
    input  logic [HISTO_W-1:0]       iGrayCumHisto,
    output logic [NREQ-1:0]          oRdValid,
    output logic [GRAY_W-1:0]        oRdGray,
    output logic [HISTO_W-1:0]       oRdHisto,
    output logic [HISTO_W-1:0]       oRdCum,
    output logic                     oIdle
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int DEPTH = DP_LAT + 1;

    hraState_t         state;
    logic [DEPTH-1:0]  tagValid;
    logic [PTR_W-1:0]  tagIdx  [DEPTH];
    logic [GRAY_W-1:0] tagAddr [DEPTH];

    logic              issueEn;
    logic              issue;
    logic [PTR_W-1:0]  gntIdx;
    logic [GRAY_W-1:0] selAddr;
    logic              pipeEmpty;

    // Busy blocks the grant in the very cycle it rises, before the FSM has moved.
    assign issueEn   = (state == RUN) && !iHistBusy;
    assign pipeEmpty = ~|tagValid;
    assign oIdle     = ~|iReq && pipeEmpty && (state == RUN);

    hra_rr_arbiter #(.NREQ(NREQ)) uArb (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iReq    (iReq),
        .iEn     (issueEn),
        .oGnt    (oGnt),
        .oGntIdx (gntIdx),
        .oIssue  (issue)
    );

    always_comb begin
        selAddr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gntIdx == PTR_W'(i)) selAddr = iAddr[i*GRAY_W +: GRAY_W];
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (iHistBusy) state <= HOLD;
                HOLD:    if (!iHistBusy) state <= DRAIN;
                DRAIN: begin
                    if (iHistBusy)      state <= HOLD;
                    else if (pipeEmpty) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Tag pipe: stage j holds the read issued j+1 edges ago; the last stage lines
    // up with the cycle in which the engine presents that read's data.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oReadGray <= '0;
            tagValid  <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                tagIdx[j]  <= '0;
                tagAddr[j] <= '0;
            end
        end else begin
            if (issue) oReadGray <= selAddr;
            tagValid   <= {tagValid[DEPTH-2:0], issue};
            tagIdx[0]  <= gntIdx;
            tagAddr[0] <= selAddr;
            for (int j = 1; j < DEPTH; j++) begin
                tagIdx[j]  <= tagIdx[j-1];
                tagAddr[j] <= tagAddr[j-1];
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oRdValid <= '0;
            oRdGray  <= '0;
            oRdHisto <= '0;
            oRdCum   <= '0;
        end else begin
            oRdValid <= tagValid[DEPTH-1] ? (NREQ'(1) << tagIdx[DEPTH-1]) : '0;
            if (tagValid[DEPTH-1]) begin
                oRdGray  <= tagAddr[DEPTH-1];
                oRdHisto <= iGrayHisto;
                oRdCum   <= iGrayCumHisto;
            end
        end
    end

endmodule
